// File: rtl/pll_lock_monitor.sv
// rtl/pll_lock_monitor.sv - PLL lock qualifier with reset hold, loss pulse and loss counter
// Optional macro PLL_LOCK_LOSS_CNT_EN enables the saturating loss_cnt register.
module pll_lock_monitor #(
   parameter int unsigned LOCK_STABLE_CYCLES = 1024,
   parameter int unsigned RST_HOLD_CYCLES    = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       lock_i,
   output logic       rst_out,
   output logic       ready,
   output logic       lost_pulse,
   output logic [7:0] loss_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_STABLE,
      HOLD_RST,
      RUN
   } state_t;

   localparam logic [15:0] LOCK_LAST = 16'(LOCK_STABLE_CYCLES - 1);
   localparam logic [15:0] HOLD_LAST = 16'(RST_HOLD_CYCLES - 1);

   state_t      r_state;
   logic [15:0] r_cnt;
   logic        r_sync1;
   logic        r_sync2;
   logic        r_rst_out;
   logic        r_ready;
   logic        r_lost_pulse;
   logic        w_lock_s;
   logic        w_loss_event;

   assign w_lock_s     = r_sync2;
   assign w_loss_event = (r_state == RUN) && !w_lock_s;

   // raw PLL lock is asynchronous to clk; only the second stage is used
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= lock_i;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_cnt        <= 16'd0;
         r_rst_out    <= 1'b1;
         r_ready      <= 1'b0;
         r_lost_pulse <= 1'b0;
      end else begin
         r_lost_pulse <= 1'b0;
         case (r_state)
            IDLE: begin
               r_cnt     <= 16'd0;
               r_rst_out <= 1'b1;
               r_ready   <= 1'b0;
               if (w_lock_s) begin
                  r_state <= WAIT_STABLE;
               end
            end
            WAIT_STABLE: begin
               r_rst_out <= 1'b1;
               r_ready   <= 1'b0;
               if (!w_lock_s) begin
                  r_state <= IDLE;
                  r_cnt   <= 16'd0;
               end else if (r_cnt == LOCK_LAST) begin
                  r_state <= HOLD_RST;
                  r_cnt   <= 16'd0;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            HOLD_RST: begin
               if (!w_lock_s) begin
                  r_state   <= IDLE;
                  r_cnt     <= 16'd0;
                  r_rst_out <= 1'b1;
                  r_ready   <= 1'b0;
               end else if (r_cnt == HOLD_LAST) begin
                  // outputs follow the next state so release lands on the RUN entry edge
                  r_state   <= RUN;
                  r_cnt     <= 16'd0;
                  r_rst_out <= 1'b0;
                  r_ready   <= 1'b1;
               end else begin
                  r_cnt     <= r_cnt + 16'd1;
                  r_rst_out <= 1'b1;
                  r_ready   <= 1'b0;
               end
            end
            RUN: begin
               r_cnt <= 16'd0;
               if (!w_lock_s) begin
                  r_state      <= IDLE;
                  r_rst_out    <= 1'b1;
                  r_ready      <= 1'b0;
                  r_lost_pulse <= 1'b1;
               end else begin
                  r_rst_out <= 1'b0;
                  r_ready   <= 1'b1;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_cnt     <= 16'd0;
               r_rst_out <= 1'b1;
               r_ready   <= 1'b0;
            end
         endcase
      end
   end

   assign rst_out    = r_rst_out;
   assign ready      = r_ready;
   assign lost_pulse = r_lost_pulse;

`ifdef PLL_LOCK_LOSS_CNT_EN
   logic [7:0] r_loss_cnt;

   // saturates at 255; lost_pulse keeps firing regardless
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_loss_cnt <= 8'd0;
      end else if (w_loss_event && (r_loss_cnt != 8'hFF)) begin
         r_loss_cnt <= r_loss_cnt + 8'd1;
      end
   end

   assign loss_cnt = r_loss_cnt;
`else
   logic w_unused_loss;

   assign w_unused_loss = w_loss_event;
   assign loss_cnt      = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_monitor.sv
// tb/tb_pll_lock_monitor.sv - directed vector bench for pll_lock_monitor (4/2 cycle config)
// Loss counter expectations follow PLL_LOCK_LOSS_CNT_EN.
module tb_pll_lock_monitor;

   localparam int unsigned LSC = 4;
   localparam int unsigned RHC = 2;
`ifdef PLL_LOCK_LOSS_CNT_EN
   localparam int LC = 1;
`else
   localparam int LC = 0;
`endif

   logic       clk;
   logic       rst;
   logic       lock_i;
   logic       rst_out;
   logic       ready;
   logic       lost_pulse;
   logic [7:0] loss_cnt;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       pre_rst;
      logic       lock;
      logic       e_rst;
      logic       e_lost;
      logic [7:0] e_loss;
   } vec_t;

   vec_t vecs[$];

   pll_lock_monitor #(
      .LOCK_STABLE_CYCLES(LSC),
      .RST_HOLD_CYCLES   (RHC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .lock_i    (lock_i),
      .rst_out   (rst_out),
      .ready     (ready),
      .lost_pulse(lost_pulse),
      .loss_cnt  (loss_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // drive the level sampled at the next edge, return 1 time unit after that edge
   task automatic step(input logic lk);
      lock_i = lk;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst    = 1'b1;
      lock_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset rst_out", 32'(rst_out), 32'd1);
      check("reset ready", 32'(ready), 32'd0);
      check("reset lost_pulse", 32'(lost_pulse), 32'd0);
      check("reset loss_cnt", 32'(loss_cnt), 32'd0);
      rst = 1'b0;
   endtask

   function automatic logic [7:0] exp_loss(input int n);
      if (LC == 0) return 8'd0;
      return (n > 255) ? 8'd255 : 8'(n);
   endfunction

   initial begin
      int  pulses;
      bit  got;
      vec_t v;

      rst    = 1'b1;
      lock_i = 1'b0;

      // edge e of a segment: lock_i sampled at e, outputs checked just after e
      for (int e = 0; e <= 26; e++) begin
         v.pre_rst = (e == 0);
         v.lock    = (e < 11) || (e >= 16);
         v.e_rst   = !(((e >= 8) && (e <= 12)) || (e >= 24));
         v.e_lost  = (e == 13);
         v.e_loss  = (e >= 13) ? exp_loss(1) : 8'd0;
         vecs.push_back(v);
      end
      for (int e = 0; e <= 17; e++) begin
         v.pre_rst = (e == 0);
         v.lock    = !((e >= 4) && (e <= 6));
         v.e_rst   = (e < 15);
         v.e_lost  = 1'b0;
         v.e_loss  = 8'd0;
         vecs.push_back(v);
      end

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].pre_rst) do_reset();
         step(vecs[i].lock);
         check($sformatf("vec%0d rst_out", i), 32'(rst_out), 32'(vecs[i].e_rst));
         check($sformatf("vec%0d ready", i), 32'(ready), 32'(!vecs[i].e_rst));
         check($sformatf("vec%0d lost_pulse", i), 32'(lost_pulse), 32'(vecs[i].e_lost));
         check($sformatf("vec%0d loss_cnt", i), 32'(loss_cnt), 32'(vecs[i].e_loss));
      end

      // sub-period glitch in RUN that no edge samples
      for (int k = 0; k < 4; k++) begin
         lock_i = 1'b0;
         #3;
         lock_i = 1'b1;
         step(1'b1);
         check("glitch rst_out", 32'(rst_out), 32'd0);
         check("glitch lost_pulse", 32'(lost_pulse), 32'd0);
      end

      // 260 qualify/loss rounds to reach saturation
      do_reset();
      pulses = 0;
      for (int it = 0; it < 260; it++) begin
         got = 0;
         for (int k = 0; k < 40 && !got; k++) begin
            step(1'b1);
            if (ready) got = 1;
         end
         check("sat qualify", 32'(got), 32'd1);
         got = 0;
         for (int k = 0; k < 10 && !got; k++) begin
            step(1'b0);
            if (lost_pulse) begin
               got = 1;
               pulses++;
            end
         end
         check("sat lost_pulse", 32'(got), 32'd1);
         check("sat loss_cnt", 32'(loss_cnt), 32'(exp_loss(pulses)));
         step(1'b0);
         check("sat pulse width", 32'(lost_pulse), 32'd0);
      end
      check("sat pulse count", 32'(pulses), 32'd260);
      check("sat final loss_cnt", 32'(loss_cnt), 32'(LC * 255));

      // async reset between edges while in HOLD_RST
      for (int e = 0; e < 8; e++) step(1'b1);
      check("hold rst_out", 32'(rst_out), 32'd1);
      check("hold ready", 32'(ready), 32'd0);
      check("hold loss_cnt", 32'(loss_cnt), 32'(LC * 255));
      #3;
      rst = 1'b1;
      #1;
      check("async rst_out", 32'(rst_out), 32'd1);
      check("async ready", 32'(ready), 32'd0);
      check("async loss_cnt", 32'(loss_cnt), 32'd0);
      check("async lost_pulse", 32'(lost_pulse), 32'd0);
      @(posedge clk);
      #1;
      check("async held lost_pulse", 32'(lost_pulse), 32'd0);
      rst = 1'b0;
      step(1'b1);
      check("post rst rst_out", 32'(rst_out), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pll_lock_monitor.md
PLL_LOCK_MONITOR -- requirements
Module: pll_lock_monitor

Interface
REQ-001 The block SHALL have parameter LOCK_STABLE_CYCLES, default 1024, the number of consecutive synchronized-lock cycles required before the reset hold begins (legal range 1..65535).
REQ-002 The block SHALL have parameter RST_HOLD_CYCLES, default 16, the number of cycles downstream reset stays asserted after lock qualifies (legal range 1..65535).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, driven by the PLL output clock.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port lock_i, input, 1 bit: raw PLL LOCK, asynchronous to clk.
REQ-006 The block SHALL have port rst_out, output, 1 bit: active-high synchronous reset for downstream logic.
REQ-007 The block SHALL have port ready, output, 1 bit: high while the clock is qualified and downstream is running.
REQ-008 The block SHALL have port lost_pulse, output, 1 bit: one-cycle pulse on each loss of lock while running.
REQ-009 The block SHALL have port loss_cnt, output, 8 bits: saturating count of lock losses.

Function
REQ-010 lock_i SHALL pass through a 2-flop synchronizer; its second stage is lock_s.
REQ-011 The FSM SHALL have exactly four states: IDLE, WAIT_STABLE, HOLD_RST and RUN, plus one shared 16-bit counter cnt.
REQ-012 In IDLE with lock_s=1, the FSM SHALL move to WAIT_STABLE with cnt=0 at the next edge; with lock_s=0 it SHALL stay in IDLE with cnt=0.
REQ-013 In WAIT_STABLE, cnt SHALL increment each cycle lock_s=1; when cnt==LOCK_STABLE_CYCLES-1 and lock_s=1, the FSM SHALL move to HOLD_RST with cnt=0.
REQ-014 In HOLD_RST, cnt SHALL increment each cycle lock_s=1; when cnt==RST_HOLD_CYCLES-1 and lock_s=1, the FSM SHALL move to RUN.
REQ-015 In WAIT_STABLE or HOLD_RST, lock_s=0 SHALL force IDLE and cnt=0 at the next edge, with no lost_pulse and no loss_cnt change.
REQ-016 In RUN, lock_s=0 SHALL force IDLE at the next edge, set lost_pulse=1 for exactly that one cycle, and increment loss_cnt.
REQ-017 rst_out SHALL be a registered output, 0 only while the state is RUN and 1 in every other state.
REQ-018 ready SHALL be a registered output equal to the inverse of rst_out.
REQ-019 Latency: with lock_i sampled high at edge 0 and held, rst_out SHALL fall and ready SHALL rise at edge 2+LOCK_STABLE_CYCLES+RST_HOLD_CYCLES.
REQ-020 When lock_s falls in RUN, rst_out SHALL be 1 from the edge after the lock_s fall.
REQ-021 A lock_i glitch shorter than one clk period that is not captured by the synchronizer SHALL have no effect.
REQ-022 loss_cnt SHALL saturate at 255; a loss at 255 SHALL still pulse lost_pulse.

Reset
REQ-023 rst=1 SHALL asynchronously force: the FSM to IDLE, cnt=0, both synchronizer flops=0, rst_out=1, ready=0, lost_pulse=0, loss_cnt=0.
REQ-024 Release of rst SHALL be honoured on the next clk edge; the qualification sequence SHALL restart from IDLE regardless of the lock_i level.
REQ-025 rst asserted mid-sequence (any state) SHALL abort the sequence with no lost_pulse and with loss_cnt cleared.

Configuration
REQ-026 With macro PLL_LOCK_LOSS_CNT_EN defined, the loss_cnt register and its saturation logic SHALL be present as specified in REQ-016 and REQ-022.
REQ-027 Without PLL_LOCK_LOSS_CNT_EN, loss_cnt SHALL be tied to 8'd0 with no counter flops, and lost_pulse SHALL be unchanged.

Verification (LOCK_STABLE_CYCLES=4, RST_HOLD_CYCLES=2)
REQ-028 Reset, then lock_i=1 held from edge 0 -> rst_out=1 and ready=0 through edge 7; rst_out=0 and ready=1 after edge 8; lost_pulse stays 0.
REQ-029 lock_i drops for 3 cycles during WAIT_STABLE -> FSM returns to IDLE; after lock_i returns, the full 8-cycle qualification restarts; loss_cnt=0.
REQ-030 In RUN, lock_i=0 for 5 cycles -> rst_out=1 three edges after the drop; exactly one lost_pulse; loss_cnt=1; requalifies after lock_i returns.
REQ-031 260 RUN/loss cycles -> loss_cnt reads 255; 260 lost_pulse events are counted; with PLL_LOCK_LOSS_CNT_EN undefined, loss_cnt=0 throughout.
REQ-032 rst asserted asynchronously mid-HOLD_RST, between clock edges -> rst_out=1, ready=0 and loss_cnt=0 immediately; no lost_pulse.
